// File: rtl/bouncing_box_source_if.sv
// Pixel-side bus between the VGA timing stage (master) and the bouncing box pixel source (slave).
interface bouncing_box_source_if;
  logic       pixelEn;
  logic       display;
  logic       newFrame;
  logic       freeze;
  logic [2:0] color;
  logic [7:0] bounceCount;

  modport master (
    output pixelEn, display, newFrame, freeze,
    input  color, bounceCount
  );

  modport slave (
    input  pixelEn, display, newFrame, freeze,
    output color, bounceCount
  );
endinterface

// File: rtl/bouncing_box_source.sv
// Paints a solid box over a background. The box moves diagonally once per frame and bounces off
// the visible-area edges.
module bouncing_box_source #(
  parameter int         hDisplay = 640,
  parameter int         vDisplay = 480,
  parameter int         boxSize  = 32,
  parameter int         step     = 2,
  parameter int         startX   = 0,
  parameter int         startY   = 0,
  parameter logic [2:0] boxColor = 3'b010,
  parameter logic [2:0] bgColor  = 3'b100
) (
  input  logic                  clk,
  input  logic                  rst,
  bouncing_box_source_if.slave  bus
);

  localparam logic [10:0] H_LIM = 11'(hDisplay);
  localparam logic [10:0] V_LIM = 11'(vDisplay);
  localparam logic [10:0] SIZE  = 11'(boxSize);
  localparam logic [10:0] STEP  = 11'(step);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_prev_display;
  logic [9:0] r_box_x;
  logic [9:0] r_box_y;
  logic       r_dir_x;
  logic       r_dir_y;
  logic [2:0] r_color;
  logic [7:0] r_bounce_cnt;

  // Returns {bounced, next_dir, next_pos}. The 11-bit math keeps pos+step+size from overflowing.
  function automatic logic [11:0] move_axis(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [9:0]  np;
    logic        nd;
    logic        hit;
    p   = {1'b0, pos};
    np  = pos;
    nd  = dir;
    hit = 1'b0;
    if (dir) begin
      if (p + STEP + SIZE > lim) begin
        np  = 10'(lim - SIZE);
        nd  = 1'b0;
        hit = 1'b1;
      end else begin
        np = 10'(p + STEP);
      end
    end else if (p < STEP) begin
      np  = '0;
      nd  = 1'b1;
      hit = 1'b1;
    end else begin
      np = 10'(p - STEP);
    end
    return {hit, nd, np};
  endfunction

  logic [11:0] w_move_x;
  logic [11:0] w_move_y;
  logic        w_in_x;
  logic        w_in_y;
  logic [7:0]  w_bounce_next;

  assign w_move_x = move_axis(r_box_x, r_dir_x, H_LIM);
  assign w_move_y = move_axis(r_box_y, r_dir_y, V_LIM);

  assign w_in_x = ({1'b0, r_x} >= {1'b0, r_box_x}) && ({1'b0, r_x} < {1'b0, r_box_x} + SIZE);
  assign w_in_y = ({1'b0, r_y} >= {1'b0, r_box_y}) && ({1'b0, r_y} < {1'b0, r_box_y} + SIZE);

  assign w_bounce_next = r_bounce_cnt + {7'b0, w_move_x[11]} + {7'b0, w_move_y[11]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x            <= '0;
      r_y            <= '0;
      r_prev_display <= 1'b0;
      r_box_x        <= 10'(startX);
      r_box_y        <= 10'(startY);
      r_dir_x        <= 1'b1;
      r_dir_y        <= 1'b1;
      r_color        <= 3'b000;
      r_bounce_cnt   <= '0;
    end else begin
      // newFrame wins over a coincident pixel advance; the box only moves here so no frame tears.
      if (bus.newFrame) begin
        r_x            <= '0;
        r_y            <= '0;
        r_prev_display <= 1'b0;
        if (!bus.freeze) begin
          r_box_x      <= w_move_x[9:0];
          r_dir_x      <= w_move_x[10];
          r_box_y      <= w_move_y[9:0];
          r_dir_y      <= w_move_y[10];
          r_bounce_cnt <= w_bounce_next;
        end
      end else if (bus.pixelEn) begin
        if (bus.display) begin
          if (r_x != 10'd1023) r_x <= r_x + 10'd1;
        end else if (r_prev_display) begin
          r_x <= '0;
          if (r_y != 10'd1023) r_y <= r_y + 10'd1;
        end
        r_prev_display <= bus.display;
      end

      if (bus.pixelEn) begin
        if (!bus.display)          r_color <= 3'b000;
        else if (w_in_x && w_in_y) r_color <= boxColor;
        else                       r_color <= bgColor;
      end
    end
  end

  assign bus.color       = r_color;
  assign bus.bounceCount = r_bounce_cnt;

endmodule
